// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared types, BCD constants and helpers for the MM:SS stopwatch
// Revision    : 1.0
// ============================================================================
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [0:0] {
        PAUSED = 1'b0,
        RUN    = 1'b1
    } state_t;

    localparam bcd_t SEC_MAX_TENS = 4'd5;
    localparam bcd_t BCD_MAX      = 4'd9;

    // Packs a 0..99 value as {tens, ones} for compile-time comparison
    function automatic logic [7:0] to_bcd2(input int value);
        return {4'(value / 10), 4'(value % 10)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_core_rise_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : rise_edge_detect
// Description : Registered one-cycle pulse on each 0->1 transition of lvl
// Revision    : 1.0
// ============================================================================
module rise_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    output logic pulse
);

    logic r_lvl_q;
    logic r_pulse_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lvl_q   <= 1'b0;
            r_pulse_q <= 1'b0;
        end else begin
            r_lvl_q   <= lvl;
            r_pulse_q <= lvl & ~r_lvl_q;
        end
    end

    assign pulse = r_pulse_q;

endmodule
`default_nettype wire

// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_core
// Description : MM:SS BCD stopwatch with run/pause, clear and field adjust
// Revision    : 1.0
// ============================================================================
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lvl_1hz,
    input  logic       lvl_2hz,
    input  logic       pause_p,
    input  logic       clr_p,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running
);

    localparam logic [7:0] c_MAX_MIN_BCD = to_bcd2(MAX_MIN);

    logic   w_tick_1hz;
    logic   w_tick_2hz;

    state_t r_state_q, w_state_d;
    bcd_t   r_min_tens_q, w_min_tens_d;
    bcd_t   r_min_ones_q, w_min_ones_d;
    bcd_t   r_sec_tens_q, w_sec_tens_d;
    bcd_t   r_sec_ones_q, w_sec_ones_d;
    logic   r_running_q;
    logic   w_sec_wrap;

    rise_edge_detect u_edge_1hz (
        .clk   (clk),
        .rst   (rst),
        .lvl   (lvl_1hz),
        .pulse (w_tick_1hz)
    );

    rise_edge_detect u_edge_2hz (
        .clk   (clk),
        .rst   (rst),
        .lvl   (lvl_2hz),
        .pulse (w_tick_2hz)
    );

    assign w_sec_wrap = (r_sec_tens_q == SEC_MAX_TENS) && (r_sec_ones_q == BCD_MAX);

    always_comb begin
        w_min_tens_d = r_min_tens_q;
        w_min_ones_d = r_min_ones_q;
        w_sec_tens_d = r_sec_tens_q;
        w_sec_ones_d = r_sec_ones_q;
        w_state_d    = pause_p ? ((r_state_q == RUN) ? PAUSED : RUN) : r_state_q;

        if (clr_p) begin
            w_min_tens_d = '0;
            w_min_ones_d = '0;
            w_sec_tens_d = '0;
            w_sec_ones_d = '0;
        end else if ((adj && w_tick_2hz && sel) ||
                     (!adj && (r_state_q == RUN) && w_tick_1hz)) begin
            // Seconds step; carry into minutes only while counting
            if (r_sec_ones_q == BCD_MAX) begin
                w_sec_ones_d = '0;
                w_sec_tens_d = (r_sec_tens_q == SEC_MAX_TENS) ? '0 : r_sec_tens_q + 4'd1;
            end else begin
                w_sec_ones_d = r_sec_ones_q + 4'd1;
            end
        end

        if (!clr_p && ((adj && w_tick_2hz && !sel) ||
                       (!adj && (r_state_q == RUN) && w_tick_1hz && w_sec_wrap))) begin
            if ({r_min_tens_q, r_min_ones_q} == c_MAX_MIN_BCD) begin
                w_min_tens_d = '0;
                w_min_ones_d = '0;
            end else if (r_min_ones_q == BCD_MAX) begin
                w_min_ones_d = '0;
                w_min_tens_d = r_min_tens_q + 4'd1;
            end else begin
                w_min_ones_d = r_min_ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q    <= PAUSED;
            r_running_q  <= 1'b0;
            r_min_tens_q <= '0;
            r_min_ones_q <= '0;
            r_sec_tens_q <= '0;
            r_sec_ones_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_running_q  <= (w_state_d == RUN);
            r_min_tens_q <= w_min_tens_d;
            r_min_ones_q <= w_min_ones_d;
            r_sec_tens_q <= w_sec_tens_d;
            r_sec_ones_q <= w_sec_ones_d;
        end
    end

    assign min_tens = r_min_tens_q;
    assign min_ones = r_min_ones_q;
    assign sec_tens = r_sec_tens_q;
    assign sec_ones = r_sec_ones_q;
    assign running  = r_running_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_core
// Description : Directed and random checks of stopwatch_core against a time model
// Revision    : 1.0
// ============================================================================
module tb_stopwatch_core;

    localparam int MAX_MIN = 59;
    localparam int PERIOD  = (MAX_MIN + 1) * 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lvl_1hz = 1'b0;
    logic       lvl_2hz = 1'b0;
    logic       pause_p = 1'b0;
    logic       clr_p = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running;

    int checks = 0;
    int errors = 0;

    // Model: elapsed seconds modulo the full display period, plus run flag
    int   m_t   = 0;
    logic m_run = 1'b0;

    stopwatch_core #(.MAX_MIN(MAX_MIN)) dut (
        .clk      (clk),
        .rst      (rst),
        .lvl_1hz  (lvl_1hz),
        .lvl_2hz  (lvl_2hz),
        .pause_p  (pause_p),
        .clr_p    (clr_p),
        .adj      (adj),
        .sel      (sel),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag);
        int mm, ss;
        logic [16:0] obs, exp;
        mm  = m_t / 60;
        ss  = m_t % 60;
        exp = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), m_run};
        obs = {min_tens, min_ones, sec_tens, sec_ones, running};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_count();
        if (!adj && m_run) m_t = (m_t + 1) % PERIOD;
    endtask

    task automatic model_adjust();
        int mm, ss;
        mm = m_t / 60;
        ss = m_t % 60;
        if (adj) begin
            if (sel) ss = (ss + 1) % 60;
            else     mm = (mm + 1) % (MAX_MIN + 1);
        end
        m_t = mm * 60 + ss;
    endtask

    task automatic edge_1hz();
        lvl_1hz = 1'b1;
        repeat (3) @(negedge clk);
        lvl_1hz = 1'b0;
        repeat (2) @(negedge clk);
        model_count();
    endtask

    task automatic edge_2hz();
        lvl_2hz = 1'b1;
        repeat (3) @(negedge clk);
        lvl_2hz = 1'b0;
        repeat (2) @(negedge clk);
        model_adjust();
    endtask

    task automatic do_pause();
        pause_p = 1'b1;
        @(negedge clk);
        pause_p = 1'b0;
        repeat (2) @(negedge clk);
        m_run = ~m_run;
    endtask

    task automatic do_clr();
        clr_p = 1'b1;
        @(negedge clk);
        clr_p = 1'b0;
        repeat (2) @(negedge clk);
        m_t = 0;
    endtask

    // Pulse lands in the same cycle as the internal 1 Hz tick
    task automatic tick_with(input bit is_clr);
        lvl_1hz = 1'b1;
        @(negedge clk);
        if (is_clr) clr_p = 1'b1; else pause_p = 1'b1;
        @(negedge clk);
        clr_p   = 1'b0;
        pause_p = 1'b0;
        @(negedge clk);
        lvl_1hz = 1'b0;
        repeat (2) @(negedge clk);
        if (is_clr) begin
            m_t = 0;
        end else begin
            model_count();
            m_run = ~m_run;
        end
    endtask

    task automatic set_time(input int mm, input int ss);
        int guard;
        adj = 1'b1;
        sel = 1'b0;
        guard = 0;
        while ((m_t / 60) != mm && guard < 200) begin edge_2hz(); guard++; end
        sel = 1'b1;
        while ((m_t % 60) != ss && guard < 400) begin edge_2hz(); guard++; end
        adj = 1'b0;
        sel = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("after_release");

        do_pause();
        check("run_on");
        repeat (3) edge_1hz();
        check("count_3s");

        set_time(0, 59);
        edge_1hz();
        check("sec_carry_to_min");
        set_time(59, 59);
        edge_1hz();
        check("full_wrap");

        set_time(5, 58);
        adj = 1'b1;
        sel = 1'b1;
        @(negedge clk);
        repeat (3) edge_2hz();
        check("adj_sec_wrap");
        edge_1hz();
        check("adj_ignores_1hz");

        sel = 1'b0;
        adj = 1'b0;
        set_time(59, 30);
        adj = 1'b1;
        @(negedge clk);
        edge_2hz();
        check("adj_min_wrap");
        adj = 1'b0;
        @(negedge clk);

        set_time(0, 10);
        if (!m_run) do_pause();
        tick_with(1'b0);
        check("pause_with_tick");
        edge_1hz();
        edge_1hz();
        check("paused_hold");

        set_time(12, 34);
        do_pause();
        tick_with(1'b1);
        check("clr_with_tick");
        edge_1hz();
        edge_1hz();
        check("count_after_clr");

        #2 rst = 1'b1;
        #1;
        m_t = 0;
        m_run = 1'b0;
        check("async_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_released");

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 6))
                0, 1: edge_1hz();
                2:    edge_2hz();
                3:    do_pause();
                4:    if ($urandom_range(0, 3) == 0) do_clr(); else edge_1hz();
                5:    begin adj = ~adj; @(negedge clk); end
                default: begin sel = ~sel; @(negedge clk); end
            endcase
            check("random_op");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
